// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the program loader
package loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    PAYLOAD,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs payload bytes little-endian into 32-bit words
module word_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_done,
  output logic [31:0] word_next
);

  logic [1:0]  lane;
  logic [23:0] low_bytes;

  // The fourth byte completes the word combinationally; the owner registers it.
  assign word_done = byte_valid && (lane == 2'(BYTES_PER_WORD - 1));
  assign word_next = {byte_data, low_bytes};

  // Lane counter and storage for the first three bytes of the current word.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      lane      <= '0;
      low_bytes <= '0;
    end else if (byte_valid) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    low_bytes[7:0]   <= byte_data;
        2'd1:    low_bytes[15:8]  <= byte_data;
        2'd2:    low_bytes[23:16] <= byte_data;
        default: low_bytes        <= '0;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a checksummed program image into instruction memory
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  loader_state_t state, state_next;

  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_field;
  logic [7:0]  xor_acc;
  logic        accept;
  logic        payload_accept;
  logic        restart;
  logic        word_done;
  logic [31:0] word_next;

  assign accept         = in_valid && in_ready;
  assign payload_accept = accept && (state == PAYLOAD);
  assign restart        = reload && ((state == DONE) || (state == ERROR));
  assign len_field      = {in_data, len_lo};

  word_assembler u_word_assembler (
    .clock      (clock),
    .reset      (reset),
    .clear      (restart),
    .byte_valid (payload_accept),
    .byte_data  (in_data),
    .word_done  (word_done),
    .word_next  (word_next)
  );

  // Frame sequencing: length, payload, checksum, then park until reload.
  always_comb begin
    state_next = state;
    case (state)
      LEN_LO:  if (accept) state_next = LEN_HI;
      LEN_HI:
        if (accept) begin
          if (len_field > 16'(MAX_WORDS))  state_next = ERROR;
          else if (len_field == 16'd0)     state_next = CHECK;
          else                             state_next = PAYLOAD;
        end
      PAYLOAD: if (word_done && (words_loaded == len - 16'd1)) state_next = CHECK;
      CHECK:   if (accept) state_next = (in_data == xor_acc) ? DONE : ERROR;
      DONE,
      ERROR:   if (reload) state_next = LEN_LO;
      default: state_next = LEN_LO;
    endcase
  end

  // State, counters, checksum and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= LEN_LO;
      in_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      xor_acc      <= '0;
      len_lo       <= '0;
      len          <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next != DONE) && (state_next != ERROR);
      done      <= (state_next == DONE);
      error     <= (state_next == ERROR);
      cpu_reset <= (state_next != DONE);
      mem_we    <= word_done;
      if (accept && (state == LEN_LO)) len_lo <= in_data;
      if (accept && (state == LEN_HI)) len    <= len_field;
      if (payload_accept) xor_acc <= xor_acc ^ in_data;
      if (word_done) begin
        mem_addr     <= {words_loaded[ADDR_WIDTH-3:0], 2'b00};
        mem_wdata    <= word_next;
        words_loaded <= words_loaded + 16'd1;
      end
      if (restart) begin
        words_loaded <= '0;
        xor_acc      <= '0;
      end
    end
  end

endmodule
